// File: rtl/spi_wr_bridge.sv
// SPI write bridge: synchronises the sck-domain write strobe, captures address/data
// into a small FIFO and drains it onto a valid/ready write bus, counting overflow drops.
module spi_wr_bridge #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_in,
    input  logic [ADDR_W-1:0]        wr_addr_in,
    input  logic [DATA_W-1:0]        wr_data_in,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_fire;
    logic                   drop;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ADDR_W-1:0]      addr_mem [DEPTH];
    logic [DATA_W-1:0]      data_mem [DEPTH];

    // Chain and edge flop reset high so a strobe already asserted at release is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wr_en_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push    = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign full    = (fifo_level == LVL_W'(DEPTH));
    assign pop     = bus_valid & bus_ready;
    assign wr_fire = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_mem   <= '{default: '0};
            data_mem   <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_fire) begin
                addr_mem[wr_ptr] <= wr_addr_in;
                data_mem[wr_ptr] <= wr_data_in;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(wr_fire) - LVL_W'(pop);
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= ovf_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1);
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

    assign bus_valid = (fifo_level != '0);
    assign bus_addr  = addr_mem[rd_ptr];
    assign bus_data  = data_mem[rd_ptr];

endmodule

// File: tb/tb_spi_wr_bridge.sv
// Self-checking bench for spi_wr_bridge: directed scenarios plus randomized writes
// compared against a queue-based reference model.
module tb_spi_wr_bridge;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en_in = 1'b0;
    logic [ADDR_W-1:0] wr_addr_in = '0;
    logic [DATA_W-1:0] wr_data_in = '0;
    logic              bus_valid;
    logic              bus_ready = 1'b0;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic [2:0]        fifo_level;
    logic              ovf;
    logic              ovf_clr = 1'b0;
    logic [7:0]        drop_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t      m_q[$];
    bit          m_ovf;
    int unsigned m_cnt;
    int unsigned total;
    int unsigned bad;

    spi_wr_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_data(bus_data), .fifo_level(fifo_level), .ovf(ovf),
        .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Advance one clock; push_now marks the edge where the bench expects the write to land.
    task automatic clk_step(input bit push_now);
        bit pop;
        @(posedge clk);
        pop = bus_ready && (m_q.size() != 0) && rst_n;
        if (pop) void'(m_q.pop_front());
        if (push_now && rst_n) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back('{a: wr_addr_in, d: wr_data_in});
            end else begin
                m_ovf = 1'b1;
                m_cnt = ovf_clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
            end
        end else if (ovf_clr && rst_n) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        #1;
    endtask

    // Leaves the bench just before the edge on which the write is pushed.
    task automatic wr_begin(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_addr_in = a;
        wr_data_in = d;
        wr_en_in   = 1'b1;
        clk_step(1'b0);
        clk_step(1'b0);
    endtask

    task automatic wr_end();
        wr_en_in = 1'b0;
        repeat (3) clk_step(1'b0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int unsigned hold);
        wr_begin(a, d);
        clk_step(1'b1);
        repeat (hold) clk_step(1'b0);
        wr_end();
    endtask

    task automatic test_reset();
        #2;
        total += 6;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d want=0", bus_valid); end
        if (bus_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h want=0", bus_addr); end
        if (bus_data !== '0) begin bad++; $display("FAIL rst_data got=%0h want=0", bus_data); end
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0d want=0", ovf); end
        if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", drop_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) clk_step(1'b0);
        total++;
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_idle_level got=%0d want=0", fifo_level); end
    endtask

    task automatic test_single();
        bus_ready = 1'b1;
        wr_begin(24'h123456, 32'hDEADBEEF);
        total += 3;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0d want=0", bus_valid); end
        clk_step(1'b1);
        if (bus_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d want=1", bus_valid); end
        if ({bus_addr, bus_data} !== {24'h123456, 32'hDEADBEEF}) begin
            bad++; $display("FAIL single_entry got=%0h/%0h want=123456/deadbeef", bus_addr, bus_data);
        end
        clk_step(1'b0);
        total += 2;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0d want=0", bus_valid); end
        if (fifo_level !== 3'(m_q.size())) begin bad++; $display("FAIL single_level got=%0d want=%0d", fifo_level, m_q.size()); end
        wr_end();
    endtask

    task automatic test_fill_drain();
        bus_ready = 1'b0;
        for (int i = 1; i <= 4; i++) do_write(ADDR_W'(i), $urandom, 2);
        total += 2;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d want=4", fifo_level); end
        if (bus_addr !== 24'd1) begin bad++; $display("FAIL fill_head got=%0d want=1", bus_addr); end
        bus_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (!bus_valid || bus_addr !== ADDR_W'(i) || bus_data !== m_q[0].d) begin
                bad++; $display("FAIL fill_order got=%0d/%0h want=%0d/%0h", bus_addr, bus_data, i, m_q[0].d);
            end
            clk_step(1'b0);
        end
        total += 2;
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL fill_empty got=%0d want=0", fifo_level); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%0d want=0", ovf); end
    endtask

    task automatic test_overflow();
        bus_ready = 1'b0;
        for (int i = 1; i <= 6; i++) do_write(ADDR_W'(i), $urandom, 0);
        total += 3;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", fifo_level); end
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d want=1", ovf); end
        if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt got=%0d want=2", drop_cnt); end
        bus_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (bus_addr !== ADDR_W'(i)) begin bad++; $display("FAIL ovf_order got=%0d want=%0d", bus_addr, i); end
            clk_step(1'b0);
        end
        ovf_clr = 1'b1;
        clk_step(1'b0);
        ovf_clr = 1'b0;
        total += 2;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr_flag got=%0d want=0", ovf); end
        if (drop_cnt !== 8'd0) begin bad++; $display("FAIL ovf_clr_cnt got=%0d want=0", drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        bus_ready = 1'b0;
        for (int i = 10; i <= 13; i++) do_write(ADDR_W'(i), $urandom, 0);
        wr_begin(24'd14, $urandom);
        bus_ready = 1'b1;
        clk_step(1'b1);
        bus_ready = 1'b0;
        total += 3;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d want=4", fifo_level); end
        if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL fpp_drop got=%0d/%0d want=0/0", ovf, drop_cnt); end
        if (bus_addr !== 24'd11) begin bad++; $display("FAIL fpp_head got=%0d want=11", bus_addr); end
        wr_end();
        bus_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            total++;
            if (bus_addr !== ADDR_W'(i)) begin bad++; $display("FAIL fpp_order got=%0d want=%0d", bus_addr, i); end
            clk_step(1'b0);
        end
    endtask

    task automatic test_reset_held();
        bus_ready = 1'b0;
        wr_addr_in = 24'hABCDEF;
        wr_en_in = 1'b1;
        clk_step(1'b0);
        rst_n = 1'b0;
        model_reset();
        clk_step(1'b0);
        rst_n = 1'b1;
        repeat (6) clk_step(1'b0);
        total++;
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL held_nopush got=%0d want=0", fifo_level); end
        wr_end();
        do_write(24'd77, 32'h77, 1);
        total += 2;
        if (fifo_level !== 3'd1) begin bad++; $display("FAIL held_push_level got=%0d want=1", fifo_level); end
        if (bus_addr !== 24'd77) begin bad++; $display("FAIL held_push_addr got=%0d want=77", bus_addr); end
        bus_ready = 1'b1;
        clk_step(1'b0);
    endtask

    task automatic test_reset_midop();
        bus_ready = 1'b0;
        for (int i = 1; i <= 3; i++) do_write(ADDR_W'(i + 40), $urandom, 0);
        total++;
        if (fifo_level !== 3'd3) begin bad++; $display("FAIL mid_level_pre got=%0d want=3", fifo_level); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0d want=0", bus_valid); end
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
        if (bus_addr !== '0) begin bad++; $display("FAIL mid_addr got=%0h want=0", bus_addr); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clk_step(1'b0);
    endtask

    task automatic test_saturate();
        bus_ready = 1'b0;
        for (int i = 0; i < DEPTH + 258; i++) do_write($urandom, $urandom, 0);
        total += 2;
        if (drop_cnt !== 8'(m_cnt) || m_cnt != 255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", drop_cnt); end
        if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0d want=1", ovf); end
        wr_begin(24'h5A5A5A, 32'h1);
        ovf_clr = 1'b1;
        clk_step(1'b1);
        ovf_clr = 1'b0;
        total += 2;
        if (ovf !== 1'b1) begin bad++; $display("FAIL clrdrop_ovf got=%0d want=1", ovf); end
        if (drop_cnt !== 8'd1) begin bad++; $display("FAIL clrdrop_cnt got=%0d want=1", drop_cnt); end
        wr_end();
        bus_ready = 1'b1;
        repeat (DEPTH) clk_step(1'b0);
        ovf_clr = 1'b1;
        clk_step(1'b0);
        ovf_clr = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            bus_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                ovf_clr = 1'b1;
                clk_step(1'b0);
                ovf_clr = 1'b0;
            end
            do_write($urandom, $urandom, $urandom_range(0, 4));
            total++;
            if (fifo_level !== 3'(m_q.size()) || bus_valid !== (m_q.size() != 0) ||
                ovf !== m_ovf || drop_cnt !== 8'(m_cnt) ||
                (m_q.size() != 0 && {bus_addr, bus_data} !== m_q[0])) begin
                bad++;
                $display("FAIL rand_state it=%0d got lvl=%0d ovf=%0d cnt=%0d head=%0h/%0h want lvl=%0d ovf=%0d cnt=%0d",
                         it, fifo_level, ovf, drop_cnt, bus_addr, bus_data, m_q.size(), m_ovf, m_cnt);
            end
        end
        bus_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            total++;
            if (fifo_level !== 3'(m_q.size()) || (m_q.size() != 0 && {bus_addr, bus_data} !== m_q[0])) begin
                bad++;
                $display("FAIL rand_drain got lvl=%0d head=%0h want lvl=%0d", fifo_level, bus_addr, m_q.size());
            end
            clk_step(1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_reset();
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_reset_held();
        test_reset_midop();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
